tuner_upmixer: RTL and testbench
================================

// Module: tuner_upmixer
//
// PURPOSE
// Transmit-side quadrature upconverter, the inverse of the receive tuner mixer.
// Takes baseband I/Q samples and produces one real IF sample: out = I*cos(ph) - Q*sin(ph).
// Contains its own NCO phase accumulator, advanced once per accepted sample, plus a quarter-wave sine LUT.
// Sits between the TX interpolation chain and the DAC sample path.
//
// PARAMETERS
// DSZ  16  data word size (in_i, in_q, out)
// PSZ  12  phase bits driving the LUT (2 quadrant bits + PSZ-2 address bits)
// FSZ  32  NCO frequency word / phase accumulator width (FSZ >= PSZ)
//
// PORTS
// clk        in   1    clock; single clock domain
// reset      in   1    synchronous, active-high reset
// in_valid   in   1    qualifies in_i/in_q; one sample per asserted cycle
// in_i       in   DSZ  signed baseband in-phase sample
// in_q       in   DSZ  signed baseband quadrature sample
// freq       in   FSZ  unsigned phase increment per sample
// freq_load  in   1    latch freq into internal frequency register
// phase_clr  in   1    zero the phase accumulator
// out_valid  out  1    qualifies out
// out        out  DSZ  signed upconverted sample
//
// BEHAVIOUR
// - Reset: acc, freq register, all pipeline data and valid bits <= 0; out=0, out_valid=0. In-flight samples discarded, never emitted.
// - freq_load: freq_reg <= freq at the clock edge; used from the next in_valid sample onward.
// - NCO: sample accepted at edge n uses ph = acc[FSZ-1:FSZ-PSZ] (pre-increment); acc <= acc + freq_reg (mod 2^FSZ). First sample after reset uses ph=0.
// - No in_valid: acc holds. phase_clr without in_valid: acc <= 0.
// - phase_clr with in_valid: that sample uses ph=0; acc <= freq_reg.
// - LUT: 2^(PSZ-2) x 16-bit signed from ./src/sine_lut.memh; entry a = round(32767*sin(2*pi*(a+0.5)/2^PSZ)).
// - sin: quad=ph[PSZ-1:PSZ-2]; cos: quad+1 (mod 4). addr = ph[PSZ-3:0] XOR {quad[0]} replicated; negate LUT value when quad[1]=1.
// - Arithmetic: pI=in_i*cos, pQ=in_q*sin (DSZ+16 signed each); sum=pI-pQ in DSZ+17 bits, no intermediate wrap.
// - Rounding: out = saturate((sum + 2^14) >>> 15), arithmetic shift (round half up); saturate to [-2^(DSZ-1), 2^(DSZ-1)-1].
// - Latency: fixed 6 cycles. Sample with in_valid at edge n -> out/out_valid updated at edge n+6.
// - Throughput 1 sample/cycle; no backpressure. out_valid reproduces the in_valid pattern delayed 6 cycles.
// - out holds last value while out_valid=0; only meaningful when out_valid=1.
// - Pipeline: phase/quad/addr reg -> LUT read -> sign apply -> 2 multiplies -> subtract -> round/sat/out reg.
//
// TESTING
// 1 freq=0, I=16384, Q=0, valid continuous -> out_valid after 6 cycles, out=16384 every sample.
// 2 freq=0, I=0, Q=16384 -> out=-12 (sin(ph=0) LUT value 25).
// 3 freq=2^30 (FSZ=32), I=16384, Q=0 -> out sequence 16384, -12, -16383, 13, repeating.
// 4 freq=0: I=-32768,Q=32767 -> out=-32768; I=32767,Q=-32768 -> out=32767 (saturation both rails).
// 5 freq=2^30, in_valid pattern 1,0,1,1,0 -> out_valid same pattern 6 cycles later; phase advances only on valid (16384,-12,-16383).
// 6 stream 10 samples, assert reset 1 cycle mid-stream -> out=0/out_valid=0 next cycle, no in-flight sample emitted; freq_reg=0 so out stays at ph=0 value.

Source files
------------

// File: rtl/tuner_upmixer.sv
// Transmit quadrature upconverter: out = I*cos(ph) - Q*sin(ph), with its own NCO phase
// accumulator and quarter-wave sine ROM. Seven register stages give a fixed 6-cycle latency.
module tuner_upmixer #(
    parameter int DSZ = 16,
    parameter int PSZ = 12,
    parameter int FSZ = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic signed [DSZ-1:0] in_i,
    input  logic signed [DSZ-1:0] in_q,
    input  logic        [FSZ-1:0] freq,
    input  logic                  freq_load,
    input  logic                  phase_clr,
    output logic                  out_valid,
    output logic signed [DSZ-1:0] out
);
    localparam int AW = PSZ - 2;
    localparam int LN = 1 << AW;
    localparam int PW = DSZ + 16;
    localparam int SW = DSZ + 17;
    localparam logic signed [SW-1:0] RND_HALF = {{(SW-15){1'b0}}, 1'b1, 14'd0};
    localparam logic signed [SW-1:0] OUT_MAX  = {{(SW-DSZ+1){1'b0}}, {(DSZ-1){1'b1}}};
    localparam logic signed [SW-1:0] OUT_MIN  = {{(SW-DSZ+1){1'b1}}, {(DSZ-1){1'b0}}};

    // Same contents as sine_lut.memh: round(32767*sin(2*pi*(a+0.5)/2^PSZ)), first quadrant only.
    function automatic logic [15:0] sine_entry(input int a);
        real ang;
        ang = 2.0 * 3.14159265358979323846 * (real'(a) + 0.5) / real'(1 << PSZ);
        return 16'($rtoi(32767.0 * $sin(ang) + 0.5));
    endfunction

    logic [15:0] lut_rom [LN];
    for (genvar g = 0; g < LN; g++) begin : g_lut
        assign lut_rom[g] = sine_entry(g);
    end

    logic        [FSZ-1:0] acc_d, acc_q, freq_d, freq_q, acc_base_s;
    logic        [PSZ-1:0] ph_s;
    logic        [1:0]     sin_quad_s, cos_quad_s;
    logic                  v1_d, v1_q, v2_d, v2_q, v3_d, v3_q, v4_d, v4_q, v5_d, v5_q, v6_d, v6_q;
    logic                  out_valid_d, out_valid_q;
    logic signed [DSZ-1:0] i1_d, i1_q, q1_d, q1_q, i2_d, i2_q, q2_d, q2_q, i3_d, i3_q, q3_d, q3_q;
    logic        [AW-1:0]  sin_addr1_d, sin_addr1_q, cos_addr1_d, cos_addr1_q;
    logic                  sin_neg1_d, sin_neg1_q, cos_neg1_d, cos_neg1_q;
    logic                  sin_neg2_d, sin_neg2_q, cos_neg2_d, cos_neg2_q;
    logic signed [15:0]    sin_raw2_d, sin_raw2_q, cos_raw2_d, cos_raw2_q;
    logic signed [15:0]    sin3_d, sin3_q, cos3_d, cos3_q;
    logic signed [PW-1:0]  pi4_d, pi4_q, pq4_d, pq4_q;
    logic signed [SW-1:0]  sum5_d, sum5_q, rnd6_d, rnd6_q;
    logic signed [DSZ-1:0] out_d, out_q;

    // Next-state logic for the NCO and every pipeline stage.
    always_comb begin
        if (freq_load) begin
            freq_d = freq;
        end else begin
            freq_d = freq_q;
        end
        // phase_clr zeroes the phase seen by this sample and the base the increment is added to
        if (phase_clr) begin
            acc_base_s = '0;
        end else begin
            acc_base_s = acc_q;
        end
        if (in_valid) begin
            acc_d = acc_base_s + freq_q;
        end else begin
            acc_d = acc_base_s;
        end
        ph_s       = acc_base_s[FSZ-1 -: PSZ];
        sin_quad_s = ph_s[PSZ-1 -: 2];
        cos_quad_s = sin_quad_s + 2'd1;

        v1_d        = in_valid;
        i1_d        = in_i;
        q1_d        = in_q;
        sin_addr1_d = ph_s[AW-1:0] ^ {AW{sin_quad_s[0]}};
        cos_addr1_d = ph_s[AW-1:0] ^ {AW{cos_quad_s[0]}};
        sin_neg1_d  = sin_quad_s[1];
        cos_neg1_d  = cos_quad_s[1];

        v2_d       = v1_q;
        i2_d       = i1_q;
        q2_d       = q1_q;
        sin_raw2_d = lut_rom[sin_addr1_q];
        cos_raw2_d = lut_rom[cos_addr1_q];
        sin_neg2_d = sin_neg1_q;
        cos_neg2_d = cos_neg1_q;

        v3_d = v2_q;
        i3_d = i2_q;
        q3_d = q2_q;
        if (sin_neg2_q) begin
            sin3_d = -sin_raw2_q;
        end else begin
            sin3_d = sin_raw2_q;
        end
        if (cos_neg2_q) begin
            cos3_d = -cos_raw2_q;
        end else begin
            cos3_d = cos_raw2_q;
        end

        v4_d  = v3_q;
        pi4_d = PW'(i3_q) * PW'(cos3_q);
        pq4_d = PW'(q3_q) * PW'(sin3_q);

        v5_d   = v4_q;
        sum5_d = SW'(pi4_q) - SW'(pq4_q);

        v6_d   = v5_q;
        rnd6_d = (sum5_q + RND_HALF) >>> 15;

        out_valid_d = v6_q;
        if (!v6_q) begin
            out_d = out_q;
        end else if (rnd6_q > OUT_MAX) begin
            out_d = OUT_MAX[DSZ-1:0];
        end else if (rnd6_q < OUT_MIN) begin
            out_d = OUT_MIN[DSZ-1:0];
        end else begin
            out_d = rnd6_q[DSZ-1:0];
        end
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0; freq_q <= '0;
            v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; v4_q <= 1'b0; v5_q <= 1'b0; v6_q <= 1'b0;
            out_valid_q <= 1'b0;
            i1_q <= '0; q1_q <= '0; i2_q <= '0; q2_q <= '0; i3_q <= '0; q3_q <= '0;
            sin_addr1_q <= '0; cos_addr1_q <= '0;
            sin_neg1_q <= 1'b0; cos_neg1_q <= 1'b0; sin_neg2_q <= 1'b0; cos_neg2_q <= 1'b0;
            sin_raw2_q <= '0; cos_raw2_q <= '0; sin3_q <= '0; cos3_q <= '0;
            pi4_q <= '0; pq4_q <= '0; sum5_q <= '0; rnd6_q <= '0; out_q <= '0;
        end else begin
            acc_q <= acc_d; freq_q <= freq_d;
            v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d; v4_q <= v4_d; v5_q <= v5_d; v6_q <= v6_d;
            out_valid_q <= out_valid_d;
            i1_q <= i1_d; q1_q <= q1_d; i2_q <= i2_d; q2_q <= q2_d; i3_q <= i3_d; q3_q <= q3_d;
            sin_addr1_q <= sin_addr1_d; cos_addr1_q <= cos_addr1_d;
            sin_neg1_q <= sin_neg1_d; cos_neg1_q <= cos_neg1_d;
            sin_neg2_q <= sin_neg2_d; cos_neg2_q <= cos_neg2_d;
            sin_raw2_q <= sin_raw2_d; cos_raw2_q <= cos_raw2_d; sin3_q <= sin3_d; cos3_q <= cos3_d;
            pi4_q <= pi4_d; pq4_q <= pq4_d; sum5_q <= sum5_d; rnd6_q <= rnd6_d; out_q <= out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
endmodule

// File: tb/tb_tuner_upmixer.sv
// Scoreboard bench for tuner_upmixer: an independent reference model pushes expected samples
// when stimulus is driven; they are popped and compared when out_valid appears.
module tb_tuner_upmixer;
    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_i = 16'sd0;
    logic signed [15:0] in_q = 16'sd0;
    logic        [31:0] freq = 32'd0;
    logic               freq_load = 1'b0;
    logic               phase_clr = 1'b0;
    logic               out_valid;
    logic signed [15:0] out;

    int total = 0;
    int bad   = 0;

    tuner_upmixer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
        .freq(freq), .freq_load(freq_load), .phase_clr(phase_clr),
        .out_valid(out_valid), .out(out)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [31:0] m_acc  = 32'd0;
    logic [31:0] m_freq = 32'd0;
    int          exp_q[$];
    bit          vhist[$];
    int          last_out = 0;

    task automatic check_val(input string tag, input longint got, input longint expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic int ref_sine(input int a);
        real x;
        x = $sin(2.0 * 3.14159265358979323846 * (real'(a) + 0.5) / 4096.0);
        return $rtoi(32767.0 * x + 0.5);
    endfunction

    // signed sin of a 12-bit phase built from the quarter-wave table
    function automatic int ref_sin_ph(input int ph);
        int quad, idx, v;
        quad = (ph >> 10) & 3;
        idx  = ph & 1023;
        if (quad % 2 == 1) idx = 1023 - idx;
        v = ref_sine(idx);
        return (quad >= 2) ? -v : v;
    endfunction

    function automatic int ref_out(input int i, input int q, input int ph);
        longint s, c, sum, r;
        s   = ref_sin_ph(ph);
        c   = ref_sin_ph((ph + 1024) % 4096);
        sum = longint'(i) * c - longint'(q) * s;
        r   = (sum + 16384) >>> 15;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic drive(input bit v, input int i, input int q, input bit pc,
                         input bit fl, input logic [31:0] f, input bit rst);
        logic [31:0] base;
        int          got_v, ev;
        reset = rst; in_valid = v; in_i = 16'(i); in_q = 16'(q);
        phase_clr = pc; freq_load = fl; freq = f;
        if (rst) begin
            m_acc = 32'd0; m_freq = 32'd0;
            exp_q.delete(); vhist.delete(); last_out = 0;
        end else begin
            base = pc ? 32'd0 : m_acc;
            if (v) begin
                exp_q.push_back(ref_out(i, q, int'(base[31:20])));
                m_acc = base + m_freq;
            end else begin
                m_acc = base;
            end
            if (fl) m_freq = f;
            vhist.push_back(v);
        end
        @(posedge clk);
        #1;
        got_v = int'(out_valid);
        if (rst) begin
            check_val("rst_valid", got_v, 0);
            check_val("rst_out", out, 0);
        end else begin
            ev = 0;
            if (vhist.size() == 7) ev = int'(vhist.pop_front());
            check_val("out_valid", got_v, ev);
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_out", out, last_out);
                end else begin
                    last_out = exp_q.pop_front();
                    check_val("out", out, last_out);
                end
            end else begin
                check_val("out_hold", out, last_out);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        drive(1'b0, 0, 0, 1'b0, 1'b0, 32'd0, 1'b1);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 32'd0, 1'b1);
        // 1: freq=0, pure I
        for (int k = 0; k < 8; k++) drive(1'b1, 16384, 0, 1'b0, 1'b0, 32'd0, 1'b0);
        // 2: pure Q at phase 0
        for (int k = 0; k < 4; k++) drive(1'b1, 0, 16384, 1'b0, 1'b0, 32'd0, 1'b0);
        // 4: saturation on both rails
        drive(1'b1, -32768, 32767, 1'b0, 1'b0, 32'd0, 1'b0);
        drive(1'b1, 32767, -32768, 1'b0, 1'b0, 32'd0, 1'b0);
        drive(1'b1, -32768, 32767, 1'b0, 1'b0, 32'd0, 1'b0);
        idle(7);
        // 3: quarter-turn per sample
        drive(1'b0, 0, 0, 1'b1, 1'b1, 32'h4000_0000, 1'b0);
        for (int k = 0; k < 8; k++) drive(1'b1, 16384, 0, 1'b0, 1'b0, 32'd0, 1'b0);
        // 5: gapped valid pattern, phase advances only on valid
        drive(1'b0, 0, 0, 1'b1, 1'b0, 32'd0, 1'b0);
        drive(1'b1, 16384, 0, 1'b0, 1'b0, 32'd0, 1'b0);
        drive(1'b0, 16384, 0, 1'b0, 1'b0, 32'd0, 1'b0);
        drive(1'b1, 16384, 0, 1'b0, 1'b0, 32'd0, 1'b0);
        drive(1'b1, 16384, 0, 1'b0, 1'b0, 32'd0, 1'b0);
        drive(1'b0, 16384, 0, 1'b0, 1'b0, 32'd0, 1'b0);
        // phase_clr together with in_valid, plus a mixed I/Q odd frequency
        drive(1'b1, 12000, -7000, 1'b1, 1'b1, 32'h1234_5679, 1'b0);
        for (int k = 0; k < 12; k++)
            drive(1'b1, 12000 - 2000 * k, 3000 * k - 15000, 1'b0, 1'b0, 32'd0, 1'b0);
        idle(7);
        // 6: reset mid-stream discards in-flight samples
        drive(1'b0, 0, 0, 1'b0, 1'b1, 32'h4000_0000, 1'b0);
        for (int k = 0; k < 4; k++) drive(1'b1, 16384, 8000, 1'b0, 1'b0, 32'd0, 1'b0);
        drive(1'b1, 16384, 8000, 1'b0, 1'b0, 32'd0, 1'b1);
        for (int k = 0; k < 5; k++) drive(1'b1, 16384, 8000, 1'b0, 1'b0, 32'd0, 1'b0);
        idle(8);
        check_val("drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
